// File: rtl/bus_dev_endpoint.sv
// -----------------------------------------------------------------------------
// bus_dev_endpoint
//
// Device-side terminal of the broadcast bus. One instance sits on each bus
// port and provides:
//   - a TX FIFO that local logic fills and the bus drains (pndng/pop/D_pop)
//   - an RX FIFO that the bus fills (push/D_push) and local logic drains
// Packets carry their destination ID in the top 8 bits.
//
// Configuration macro:
//   BUS_EP_ADDR_FILTER_EN  defined   -> only pushes addressed to `id` or
//                                       `broadcast` are stored; rejected
//                                       pushes are counted in misroute_cnt.
//                          undefined -> promiscuous: every push is a storage
//                                       candidate, misroute_cnt is tied to 0.
//
// Parameters:
//   pckg_sz    packet width in bits (>= 9)
//   depth      entries per FIFO (power of 2, >= 2)
//   id         this endpoint's 8-bit bus address
//   broadcast  destination ID accepted by every endpoint
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   tx_wr        local enqueue strobe
//   tx_data      packet to enqueue
//   tx_full      TX FIFO full
//   pndng        TX FIFO non-empty (to bus)
//   D_pop        TX head packet, first-word-fall-through, 0 when empty
//   pop          bus consumes TX head
//   push         bus delivers a packet
//   D_push       delivered packet
//   rx_rd        local dequeue strobe
//   rx_data      RX head packet, first-word-fall-through, 0 when empty
//   rx_empty     RX FIFO empty
//   rx_drop_cnt  saturating count of accepted pushes lost to a full RX FIFO
//   misroute_cnt saturating count of pushes rejected by the address filter
//   err          sticky: [0] TX overflow, [1] pop while TX empty
//
// All outputs are driven from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module bus_dev_endpoint #(
    parameter int          pckg_sz   = 16,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic [7:0]         rx_drop_cnt,
    output logic [7:0]         misroute_cnt,
    output logic [1:0]         err
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(depth);

    // -------------------------------------------------------------------------
    // TX FIFO state
    // -------------------------------------------------------------------------
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [AW-1:0]      tx_wr_ptr;
    logic [AW-1:0]      tx_rd_ptr;
    logic [AW:0]        tx_count;

    logic tx_is_empty;
    logic tx_is_full;
    logic tx_do_pop;
    logic tx_do_wr;
    logic tx_overflow;
    logic tx_underflow;

    // -------------------------------------------------------------------------
    // RX FIFO state
    // -------------------------------------------------------------------------
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [AW-1:0]      rx_wr_ptr;
    logic [AW-1:0]      rx_rd_ptr;
    logic [AW:0]        rx_count;

    logic rx_is_empty;
    logic rx_is_full;
    logic rx_addr_ok;
    logic rx_candidate;
    logic rx_do_rd;
    logic rx_do_wr;
    logic rx_drop;

    logic [1:0] err_q;
    logic [7:0] rx_drop_q;

    // -------------------------------------------------------------------------
    // TX control
    // -------------------------------------------------------------------------
    always_comb begin
        tx_is_empty  = (tx_count == '0);
        tx_is_full   = (tx_count == DEPTH_C);
        tx_do_pop    = pop & ~tx_is_empty;
        // A pop in the same cycle frees the slot, so a write to a full FIFO
        // is still accepted then.
        tx_do_wr     = tx_wr & (~tx_is_full | tx_do_pop);
        tx_overflow  = tx_wr & ~tx_do_wr;
        tx_underflow = pop & tx_is_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_do_wr) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_do_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_do_wr, tx_do_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!reset && tx_do_wr) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

    // -------------------------------------------------------------------------
    // RX address filter
    // -------------------------------------------------------------------------
`ifdef BUS_EP_ADDR_FILTER_EN
    logic [7:0] rx_dest;
    logic [7:0] misroute_q;
    logic       rx_misroute;

    always_comb begin
        rx_dest     = D_push[pckg_sz-1 -: 8];
        rx_addr_ok  = (rx_dest == id) || (rx_dest == broadcast);
        rx_misroute = push & ~rx_addr_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misroute_q <= '0;
        end else if (rx_misroute && (misroute_q != 8'hFF)) begin
            misroute_q <= misroute_q + 1'b1;
        end
    end

    assign misroute_cnt = misroute_q;
`else
    // Promiscuous mode: every delivered packet is a storage candidate.
    assign rx_addr_ok   = 1'b1;
    assign misroute_cnt = '0;
`endif

    // -------------------------------------------------------------------------
    // RX control
    // -------------------------------------------------------------------------
    always_comb begin
        rx_is_empty  = (rx_count == '0);
        rx_is_full   = (rx_count == DEPTH_C);
        rx_candidate = push & rx_addr_ok;
        rx_do_rd     = rx_rd & ~rx_is_empty;
        // A simultaneous local read makes room for an accepted push.
        rx_do_wr     = rx_candidate & (~rx_is_full | rx_do_rd);
        rx_drop      = rx_candidate & ~rx_do_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_do_wr) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_do_rd) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_do_wr, rx_do_rd})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rx_do_wr) begin
            rx_mem[rx_wr_ptr] <= D_push;
        end
    end

    // -------------------------------------------------------------------------
    // Drop counter and sticky error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_drop_q <= '0;
            err_q     <= '0;
        end else begin
            if (rx_drop && (rx_drop_q != 8'hFF)) begin
                rx_drop_q <= rx_drop_q + 1'b1;
            end
            err_q <= err_q | {tx_underflow, tx_overflow};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (functions of registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        pndng       = ~tx_is_empty;
        tx_full     = tx_is_full;
        rx_empty    = rx_is_empty;
        D_pop       = tx_is_empty ? '0 : tx_mem[tx_rd_ptr];
        rx_data     = rx_is_empty ? '0 : rx_mem[rx_rd_ptr];
        rx_drop_cnt = rx_drop_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// -----------------------------------------------------------------------------
// tb_bus_dev_endpoint
//
// Directed bench for bus_dev_endpoint (pckg_sz=16, depth=8, id=2). Each
// scenario task drives inputs just after a rising edge and checks outputs
// 1 ns after the following edge. Expectations that depend on the address
// filter are selected from the BUS_EP_ADDR_FILTER_EN build setting.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_dev_endpoint;

`ifdef BUS_EP_ADDR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_rd;
    logic [15:0] rx_data;
    logic        rx_empty;
    logic [7:0]  rx_drop_cnt;
    logic [7:0]  misroute_cnt;
    logic [1:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_dev_endpoint #(
        .pckg_sz   (16),
        .depth     (8),
        .id        (8'h02),
        .broadcast (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_drop_cnt  (rx_drop_cnt),
        .misroute_cnt (misroute_cnt),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (pndng !== 1'b0) begin n_fail++; $display("FAIL reset_pndng: got %b expected 0", pndng); end
        n_tests++;
        if (D_pop !== 16'h0000) begin n_fail++; $display("FAIL reset_D_pop: got %h expected 0000", D_pop); end
        n_tests++;
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
        n_tests++;
        if (rx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
        n_tests++;
        if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
        n_tests++;
        if ({rx_drop_cnt, misroute_cnt} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_counters: got %h/%h expected 00/00", rx_drop_cnt, misroute_cnt);
        end
        n_tests++;
        if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", err); end
    endtask

    task automatic test_tx_basic();
        tx_wr = 1'b1; tx_data = 16'h02AB;
        step();
        n_tests++;
        if ({pndng, D_pop} !== {1'b1, 16'h02AB}) begin
            n_fail++; $display("FAIL tx_first_write: got pndng=%b D_pop=%h expected 1/02AB", pndng, D_pop);
        end
        tx_data = 16'h03CD;
        step();
        tx_wr = 1'b0;
        n_tests++;
        if (D_pop !== 16'h02AB) begin n_fail++; $display("FAIL tx_head_hold: got %h expected 02AB", D_pop); end
        pop = 1'b1;
        step();
        n_tests++;
        if ({pndng, D_pop} !== {1'b1, 16'h03CD}) begin
            n_fail++; $display("FAIL tx_after_pop1: got pndng=%b D_pop=%h expected 1/03CD", pndng, D_pop);
        end
        step();
        pop = 1'b0;
        n_tests++;
        if ({pndng, D_pop} !== {1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL tx_after_pop2: got pndng=%b D_pop=%h expected 0/0000", pndng, D_pop);
        end
        n_tests++;
        if (err !== 2'b00) begin n_fail++; $display("FAIL tx_basic_err: got %b expected 00", err); end
    endtask

    task automatic test_tx_full();
        logic [15:0] exp_q [$];
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0100 + 16'(i);
            exp_q.push_back(tx_data);
            step();
        end
        tx_wr = 1'b0;
        n_tests++;
        if (tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_set: got %b expected 1", tx_full); end
        // Ninth write without pop: lost, overflow flagged.
        tx_wr = 1'b1; tx_data = 16'hDEAD;
        step();
        tx_wr = 1'b0;
        n_tests++;
        if ({tx_full, err} !== {1'b1, 2'b01}) begin
            n_fail++; $display("FAIL tx_overflow: got full=%b err=%b expected 1/01", tx_full, err);
        end
        // Write with simultaneous pop while full: accepted, still full.
        tx_wr = 1'b1; tx_data = 16'hBEEF; pop = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(16'hBEEF);
        step();
        tx_wr = 1'b0; pop = 1'b0;
        n_tests++;
        if ({tx_full, D_pop} !== {1'b1, 16'h0101}) begin
            n_fail++; $display("FAIL tx_full_wr_pop: got full=%b D_pop=%h expected 1/0101", tx_full, D_pop);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (D_pop !== exp_q[i]) begin
                n_fail++; $display("FAIL tx_drain[%0d]: got %h expected %h", i, D_pop, exp_q[i]);
            end
            pop = 1'b1;
            step();
        end
        pop = 1'b0;
        n_tests++;
        if (pndng !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got pndng=%b expected 0", pndng); end
        // Pop while empty with a write in the same cycle: write kept, err[1].
        pop = 1'b1; tx_wr = 1'b1; tx_data = 16'h0555;
        step();
        pop = 1'b0; tx_wr = 1'b0;
        n_tests++;
        if ({err, pndng, D_pop} !== {2'b11, 1'b1, 16'h0555}) begin
            n_fail++; $display("FAIL tx_underflow: got err=%b pndng=%b D_pop=%h expected 11/1/0555", err, pndng, D_pop);
        end
        pop = 1'b1;
        step();
        pop = 1'b0;
        n_tests++;
        if ({err, pndng} !== {2'b11, 1'b0}) begin
            n_fail++; $display("FAIL tx_err_sticky: got err=%b pndng=%b expected 11/0", err, pndng);
        end
    endtask

    task automatic test_rx_filter();
        logic [15:0] exp_q [$];
        logic [7:0]  exp_mis;
        exp_q.push_back(16'h0211);
        exp_q.push_back(16'hFF22);
        if (!FILT) exp_q.push_back(16'h0333);
        exp_mis = FILT ? 8'd1 : 8'd0;
        push = 1'b1; D_push = 16'h0211; step();
        D_push = 16'hFF22; step();
        D_push = 16'h0333; step();
        push = 1'b0;
        n_tests++;
        if (misroute_cnt !== exp_mis) begin
            n_fail++; $display("FAIL rx_misroute_cnt: got %0d expected %0d", misroute_cnt, exp_mis);
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if ({rx_empty, rx_data} !== {1'b0, exp_q[i]}) begin
                n_fail++; $display("FAIL rx_filter_data[%0d]: got empty=%b data=%h expected 0/%h", i, rx_empty, rx_data, exp_q[i]);
            end
            rx_rd = 1'b1;
            step();
        end
        // One extra read on an empty FIFO must be ignored.
        step();
        rx_rd = 1'b0;
        n_tests++;
        if ({rx_empty, rx_data} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL rx_filter_empty: got empty=%b data=%h expected 1/0000", rx_empty, rx_data);
        end
    endtask

    task automatic test_rx_full();
        logic [15:0] exp_q [$];
        logic [7:0]  exp_mis;
        exp_mis = FILT ? 8'd1 : 8'd0;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            exp_q.push_back(D_push);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            D_push = 16'h0299;
            step();
        end
        push = 1'b0;
        n_tests++;
        if ({rx_drop_cnt, rx_data} !== {8'd3, 16'h0200}) begin
            n_fail++; $display("FAIL rx_drop: got cnt=%0d head=%h expected 3/0200", rx_drop_cnt, rx_data);
        end
        push = 1'b1; D_push = 16'h02EE; rx_rd = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(16'h02EE);
        step();
        push = 1'b0; rx_rd = 1'b0;
        n_tests++;
        if ({rx_drop_cnt, rx_data} !== {8'd3, 16'h0201}) begin
            n_fail++; $display("FAIL rx_full_push_rd: got cnt=%0d head=%h expected 3/0201", rx_drop_cnt, rx_data);
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (rx_data !== exp_q[i]) begin
                n_fail++; $display("FAIL rx_drain[%0d]: got %h expected %h", i, rx_data, exp_q[i]);
            end
            rx_rd = 1'b1;
            step();
        end
        rx_rd = 1'b0;
        n_tests++;
        if ({rx_empty, misroute_cnt} !== {1'b1, exp_mis}) begin
            n_fail++; $display("FAIL rx_full_end: got empty=%b mis=%0d expected 1/%0d", rx_empty, misroute_cnt, exp_mis);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            tx_wr = (i < 4); tx_data = 16'h0A00 + 16'(i);
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            step();
        end
        tx_wr = 1'b0; push = 1'b0;
        n_tests++;
        if ({pndng, rx_empty, D_pop, rx_data} !== {1'b1, 1'b0, 16'h0A00, 16'h0200}) begin
            n_fail++; $display("FAIL pre_reset_state: got pndng=%b empty=%b D_pop=%h rx=%h expected 1/0/0A00/0200",
                               pndng, rx_empty, D_pop, rx_data);
        end
        reset = 1'b1; pop = 1'b1;
        step();
        reset = 1'b0; pop = 1'b0;
        n_tests++;
        if ({pndng, rx_empty, D_pop, rx_data} !== {1'b0, 1'b1, 16'h0000, 16'h0000}) begin
            n_fail++; $display("FAIL mid_reset_fifos: got pndng=%b empty=%b D_pop=%h rx=%h expected 0/1/0000/0000",
                               pndng, rx_empty, D_pop, rx_data);
        end
        n_tests++;
        if ({rx_drop_cnt, misroute_cnt, err} !== 18'h0) begin
            n_fail++; $display("FAIL mid_reset_status: got drop=%0d mis=%0d err=%b expected 0/0/00",
                               rx_drop_cnt, misroute_cnt, err);
        end
        tx_wr = 1'b1; tx_data = 16'h0777;
        step();
        tx_wr = 1'b0;
        n_tests++;
        if ({pndng, D_pop} !== {1'b1, 16'h0777}) begin
            n_fail++; $display("FAIL post_reset_write: got pndng=%b D_pop=%h expected 1/0777", pndng, D_pop);
        end
    endtask

    initial begin
        reset = 1'b1; tx_wr = 1'b0; tx_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rx_rd = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_rx_filter();
        test_rx_full();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
